// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t      : converter FSM encoding (IDLE / SHIFT / DONE)
//   DIGIT_W      : width of one BCD digit
//   ADJ_THRESH   : digit value at or above which the add-3 correction applies
//   ADJ_ADD      : correction added to a digit before the left shift
//   bcd_adjust() : one-digit "≥5 → +3" correction, 4-bit wrap, no carry out
// ----------------------------------------------------------------------------
package bcd_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam int unsigned DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
   localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

   // A valid BCD digit (0..9) never exceeds 12 after correction, so the
   // 4-bit sum cannot wrap and no carry into the next digit is needed.
   function automatic logic [DIGIT_W-1:0] bcd_adjust(input logic [DIGIT_W-1:0] digit);
      if (digit >= ADJ_THRESH) begin
         return digit + ADJ_ADD;
      end
      return digit;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational per-digit correction cell for shift-and-add-3 conversion.
// Ports:
//   i_digit : BCD digit before the shift
//   o_digit : digit with +3 applied when i_digit >= 5, else unchanged
// ----------------------------------------------------------------------------
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_digit,
   output logic [DIGIT_W-1:0] o_digit
);

   assign o_digit = bcd_adjust(i_digit);

endmodule

// File: rtl/bcd_seq.sv
// ----------------------------------------------------------------------------
// bcd_seq
// Sequential binary-to-BCD converter (double dabble), one operand bit per
// clock, valid/ready handshake on input and output, sticky overflow when the
// operand needs more than DIGITS decimal digits.
// Parameters:
//   IN_WIDTH : operand width in bits (>= 2)
//   DIGITS   : number of BCD output digits (>= 1), ones digit in [3:0]
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operand present on in
//   in_ready  : converter idle and able to accept an operand
//   in        : unsigned binary operand
//   out_valid : result present on digits/overflow
//   out_ready : consumer accepts the result
//   digits    : BCD result, digit k in [4k+3:4k]
//   overflow  : operand > 10^DIGITS - 1; digits hold the low DIGITS digits
// ----------------------------------------------------------------------------
module bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned IN_WIDTH = 16,
   parameter int unsigned DIGITS   = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [IN_WIDTH-1:0]       in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DIGIT_W*DIGITS-1:0] digits,
   output logic                      overflow
);

   localparam int unsigned ACC_W = DIGIT_W * DIGITS;
   localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

   if (IN_WIDTH < 2) begin : g_bad_in_width
      $error("bcd_seq: IN_WIDTH must be at least 2");
   end
   if (DIGITS < 1) begin : g_bad_digits
      $error("bcd_seq: DIGITS must be at least 1");
   end

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IN_WIDTH-1:0] r_op;
   logic [ACC_W-1:0]    r_acc;
   logic [ACC_W-1:0]    w_adj;
   logic                r_ovf;
   logic [CNT_W-1:0]    r_cnt;
   logic                w_last;

   // Per-digit correction of the current accumulator, applied before the shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_digit (r_acc[g*DIGIT_W +: DIGIT_W]),
         .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   assign w_last = (r_cnt == LAST_CNT);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (in_valid)  w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op  <= in;
                  r_acc <= '0;
                  r_ovf <= 1'b0;
                  r_cnt <= '0;
               end
            end
            S_SHIFT: begin
               // Operand MSB enters the ones digit; the bit leaving the top
               // digit is a lost decimal digit, hence sticky overflow.
               r_acc <= {w_adj[ACC_W-2:0], r_op[IN_WIDTH-1]};
               r_op  <= {r_op[IN_WIDTH-2:0], 1'b0};
               r_ovf <= r_ovf | w_adj[ACC_W-1];
               r_cnt <= r_cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Decoded from state only; rst gating keeps in_ready low during reset.
   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign out_valid = (r_state == S_DONE);
   assign digits    = r_acc;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bcd_seq
// Four converter instances: (16,5) main, (8,2) overflow, (10,4) sweep,
// (6,2) short operand. Stimulus pushes expected results into a queue; a
// monitor pops and compares whenever an instance hands over a result.
// ----------------------------------------------------------------------------
module tb_bcd_seq;

   typedef struct packed {
      logic [1:0]  id;
      logic [19:0] d;
      logic        o;
   } exp_t;

   logic        clk = 1'b0;
   logic [3:0]  rst_v;
   logic [3:0]  iv;
   logic [3:0]  ordy;
   wire  [3:0]  ir;
   wire  [3:0]  ov;
   wire  [3:0]  of;
   logic [15:0] din [4];
   wire  [19:0] dig_a;
   wire  [7:0]  dig_b;
   wire  [15:0] dig_c;
   wire  [7:0]  dig_d;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   exp_t        q [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   bcd_seq #(.IN_WIDTH(16), .DIGITS(5)) u_a (
      .clk(clk), .rst(rst_v[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in(din[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .digits(dig_a), .overflow(of[0])
   );
   bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) u_b (
      .clk(clk), .rst(rst_v[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in(din[1][7:0]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .digits(dig_b), .overflow(of[1])
   );
   bcd_seq #(.IN_WIDTH(10), .DIGITS(4)) u_c (
      .clk(clk), .rst(rst_v[2]), .in_valid(iv[2]), .in_ready(ir[2]), .in(din[2][9:0]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .digits(dig_c), .overflow(of[2])
   );
   bcd_seq #(.IN_WIDTH(6), .DIGITS(2)) u_d (
      .clk(clk), .rst(rst_v[3]), .in_valid(iv[3]), .in_ready(ir[3]), .in(din[3][5:0]),
      .out_valid(ov[3]), .out_ready(ordy[3]), .digits(dig_d), .overflow(of[3])
   );

   function automatic logic [19:0] dig_of(input int k);
      case (k)
         0:       return dig_a;
         1:       return {12'b0, dig_b};
         2:       return {4'b0, dig_c};
         default: return {12'b0, dig_d};
      endcase
   endfunction

   // Decimal reference: low nd digits of v by repeated division.
   function automatic logic [19:0] to_bcd(input int unsigned v, input int nd);
      logic [19:0] r = '0;
      int unsigned x = v;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic send(input int k, input logic [15:0] v, input bit push,
                       input logic [19:0] ed, input logic eo, output int unsigned acc_cyc);
      int n = 0;
      @(posedge clk);
      #1;
      din[k] = v;
      iv[k]  = 1'b1;
      while (ir[k] !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_checks++;
      if (ir[k] !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_wait: instance %0d in_ready=%b after %0d cycles, expected 1",
                  k, ir[k], n);
      end
      if (push) q.push_back('{id: 2'(k), d: ed, o: eo});
      @(posedge clk);
      #1;
      iv[k]   = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic wait_valid(input int k, output int n);
      n = 0;
      while (ov[k] !== 1'b1 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("out_valid_wait", 32'(ov[k]), 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check("queue_drained", 32'(q.size()), 32'd0);
   endtask

   task automatic pulse_reset_a();
      rst_v[0] = 1'b1;
      @(posedge clk);
      #1;
      rst_v[0] = 1'b0;
      #1;
      check("rst_in_ready",  32'(ir[0]), 32'd1);
      check("rst_out_valid", 32'(ov[0]), 32'd0);
      check("rst_digits",    32'(dig_a), 32'd0);
      check("rst_overflow",  32'(of[0]), 32'd0);
   endtask

   // Scoreboard monitor: a result transfers when valid and ready are both high.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         if (!rst_v[k] && ov[k] && ordy[k]) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: instance %0d digits=0x%0h, expected none",
                        k, dig_of(k));
            end else begin
               e = q.pop_front();
               check("result_instance", 32'(k), 32'(e.id));
               check("result_digits", 32'(dig_of(k)), 32'(e.d));
               check("result_overflow", 32'(of[k]), 32'(e.o));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t1, t2, ta;
      int          n;

      rst_v = 4'hF;
      iv    = 4'h0;
      ordy  = 4'hF;
      for (int k = 0; k < 4; k++) din[k] = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready_low", 32'(ir[0]), 32'd0);
      check("reset_out_valid",    32'(ov[0]), 32'd0);
      check("reset_digits",       32'(dig_a), 32'd0);
      check("reset_overflow",     32'(of[0]), 32'd0);
      rst_v = 4'h0;
      #1;
      check("ready_after_reset", 32'(ir[0]), 32'd1);

      // Short operand, latency IN_WIDTH = 6.
      send(3, 16'd63, 1'b1, 20'h63, 1'b0, ta);
      wait_valid(3, n);
      check("latency_w6", 32'(n), 32'd6);
      drain();

      // Default parameters: zero, all-ones, latency 16.
      send(0, 16'd0, 1'b1, 20'h00000, 1'b0, ta);
      drain();
      send(0, 16'd65535, 1'b1, 20'h65535, 1'b0, ta);
      wait_valid(0, n);
      check("latency_w16", 32'(n), 32'd16);
      drain();

      // Back-to-back accepts with out_ready held high.
      send(0, 16'd100, 1'b1, 20'h00100, 1'b0, t1);
      send(0, 16'd200, 1'b1, 20'h00200, 1'b0, t2);
      check("b2b_spacing", t2 - t1, 32'd18);
      drain();

      // Overflow and sticky flag cleared on the next accept.
      send(1, 16'd255, 1'b1, 20'h55, 1'b1, ta);
      drain();
      send(1, 16'd99, 1'b1, 20'h99, 1'b0, ta);
      drain();

      // Backpressure in DONE with in_valid toggling.
      ordy[0] = 1'b0;
      send(0, 16'd999, 1'b1, 20'h00999, 1'b0, ta);
      wait_valid(0, n);
      for (int i = 0; i < 10; i++) begin
         iv[0]  = i[0];
         din[0] = 16'($urandom);
         @(posedge clk);
         #1;
         check("bp_in_ready",  32'(ir[0]), 32'd0);
         check("bp_out_valid", 32'(ov[0]), 32'd1);
         check("bp_digits",    32'(dig_a), 32'h00999);
         check("bp_overflow",  32'(of[0]), 32'd0);
      end
      iv[0]   = 1'b0;
      ordy[0] = 1'b1;
      @(posedge clk);
      #1;
      check("release_in_ready",  32'(ir[0]), 32'd1);
      check("release_out_valid", 32'(ov[0]), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      check("no_phantom_result", 32'(ov[0]), 32'd0);
      drain();

      // Reset mid-SHIFT discards the partial conversion.
      send(0, 16'd50000, 1'b0, 20'h0, 1'b0, ta);
      repeat (4) @(posedge clk);
      #1;
      pulse_reset_a();

      // Reset while a result waits in DONE.
      ordy[0] = 1'b0;
      send(0, 16'd777, 1'b0, 20'h0, 1'b0, ta);
      wait_valid(0, n);
      pulse_reset_a();
      ordy[0] = 1'b1;
      send(0, 16'd1234, 1'b1, 20'h01234, 1'b0, ta);
      drain();

      // Exhaustive sweep at IN_WIDTH=10, DIGITS=4.
      for (int v = 0; v < 1024; v++) begin
         send(2, 16'(v), 1'b1, to_bcd(v, 4), 1'b0, ta);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
